// File: rtl/ir_sampler.sv
// IR sensor sampler: pulses the emitters, runs a left/right A2D pair and publishes readings,
// open flags and a saturated derivative term. Define IR_OPN_HYST_EN for hysteretic open flags.
module ir_sampler #(
   parameter logic [19:0] PERIOD     = 20'd100000,
   parameter logic [9:0]  SETTLE     = 10'd500,
   parameter logic [11:0] OPN_THRESH = 12'h444,
   parameter logic [11:0] HYST       = 12'h080,
   parameter logic [2:0]  LFT_CHNL   = 3'd0,
   parameter logic [2:0]  RGHT_CHNL  = 3'd1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic        cnv_cmplt,
   input  logic [11:0] res,
   output logic        strt_cnv,
   output logic [2:0]  chnnl,
   output logic        IR_en,
   output logic [11:0] lft_IR,
   output logic [11:0] rght_IR,
   output logic        lft_opn,
   output logic        rght_opn,
   output logic [8:0]  IR_Dtrm,
   output logic        vld
);

   typedef enum logic [2:0] {ST_IDLE, ST_SETTLE, ST_CNV_L, ST_CNV_R, ST_UPDATE} state_t;

   state_t             state;
   logic [19:0]        period_cnt;
   logic [9:0]         settle_cnt;
   logic [11:0]        lft_cap;
   logic [11:0]        rght_cap;
   logic signed [12:0] err_prev;
   logic               first;
   logic               tick;
   logic signed [12:0] err;
   logic signed [13:0] d;
   logic [8:0]         d_sat;
   logic               lft_opn_nxt;
   logic               rght_opn_nxt;

   assign tick = (period_cnt == PERIOD - 20'd1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         period_cnt <= '0;
      else if (tick)
         period_cnt <= '0;
      else
         period_cnt <= period_cnt + 20'd1;
   end

   // Both operands are zero-extended so the 12-bit readings subtract as unsigned magnitudes.
   always_comb begin
      err = $signed({1'b0, lft_cap}) - $signed({1'b0, rght_cap});
      d   = $signed({err[12], err}) - $signed({err_prev[12], err_prev});
      if (d > 14'sd255)
         d_sat = 9'h0FF;
      else if (d < -14'sd256)
         d_sat = 9'h100;
      else
         d_sat = d[8:0];
   end

`ifdef IR_OPN_HYST_EN
   localparam logic [12:0] CLR_LEVEL = {1'b0, OPN_THRESH} + {1'b0, HYST};

   always_comb begin
      lft_opn_nxt  = lft_opn;
      rght_opn_nxt = rght_opn;
      if (lft_cap < OPN_THRESH)
         lft_opn_nxt = 1'b1;
      else if ({1'b0, lft_cap} > CLR_LEVEL)
         lft_opn_nxt = 1'b0;
      if (rght_cap < OPN_THRESH)
         rght_opn_nxt = 1'b1;
      else if ({1'b0, rght_cap} > CLR_LEVEL)
         rght_opn_nxt = 1'b0;
   end
`else
   always_comb begin
      lft_opn_nxt  = (lft_cap < OPN_THRESH);
      rght_opn_nxt = (rght_cap < OPN_THRESH);
   end
`endif

   // Sequencer; ticks arriving outside IDLE are simply not looked at.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         settle_cnt <= '0;
         strt_cnv   <= 1'b0;
         chnnl      <= LFT_CHNL;
         IR_en      <= 1'b0;
         vld        <= 1'b0;
         lft_cap    <= '0;
         rght_cap   <= '0;
         lft_IR     <= '0;
         rght_IR    <= '0;
         lft_opn    <= 1'b0;
         rght_opn   <= 1'b0;
         IR_Dtrm    <= '0;
         err_prev   <= '0;
         first      <= 1'b1;
      end else begin
         strt_cnv <= 1'b0;
         vld      <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (tick && en) begin
                  state      <= ST_SETTLE;
                  IR_en      <= 1'b1;
                  settle_cnt <= '0;
               end
            end
            ST_SETTLE: begin
               if (settle_cnt == SETTLE - 10'd1) begin
                  state    <= ST_CNV_L;
                  strt_cnv <= 1'b1;
                  chnnl    <= LFT_CHNL;
               end else begin
                  settle_cnt <= settle_cnt + 10'd1;
               end
            end
            ST_CNV_L: begin
               if (cnv_cmplt) begin
                  lft_cap  <= res;
                  strt_cnv <= 1'b1;
                  chnnl    <= RGHT_CHNL;
                  state    <= ST_CNV_R;
               end
            end
            ST_CNV_R: begin
               if (cnv_cmplt) begin
                  rght_cap <= res;
                  IR_en    <= 1'b0;
                  state    <= ST_UPDATE;
               end
            end
            ST_UPDATE: begin
               lft_IR   <= lft_cap;
               rght_IR  <= rght_cap;
               lft_opn  <= lft_opn_nxt;
               rght_opn <= rght_opn_nxt;
               IR_Dtrm  <= first ? 9'h000 : d_sat;
               first    <= 1'b0;
               err_prev <= err;
               vld      <= 1'b1;
               state    <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
